sl_rx_ctrl: RTL

SL_RX_CTRL -- requirements
Module: sl_rx_ctrl

---
 rtl/sl_pkg.sv | 46 ++++
 rtl/sl_word_fifo.sv | 61 ++++++
 rtl/sl_rx_ctrl.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/sl_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : sl_pkg
//  Purpose  : Shared register map, STAT layout, receiver bit indices and
//             config FSM encoding for the serial-link receiver controller.
//  Revision : 1.0
// ============================================================================
package sl_pkg;

    localparam logic [1:0] C_ADDR_CFG  = 2'd0;
    localparam logic [1:0] C_ADDR_FIFO = 2'd1;
    localparam logic [1:0] C_ADDR_STAT = 2'd2;
    localparam logic [1:0] C_ADDR_MASK = 2'd3;

    localparam int C_STAT_CNT_LSB  = 0;
    localparam int C_STAT_CNT_MSB  = 2;
    localparam int C_STAT_CFG_BUSY = 3;
    localparam int C_STAT_CFG_REJ  = 4;
    localparam int C_STAT_CFG_TMO  = 5;
    localparam int C_STAT_OVF      = 6;
    localparam int C_STAT_PE       = 7;
    localparam int C_STAT_LE       = 8;
    localparam int C_STAT_LEV      = 9;
    localparam int C_STAT_ERR_LSB  = 16;
    localparam int C_STAT_ERR_MSB  = 23;

    // Receiver status bits
    localparam int C_RXS_WLC = 0;
    localparam int C_RXS_WRP = 2;
    localparam int C_RXS_WRF = 3;
    localparam int C_RXS_PEF = 4;
    localparam int C_RXS_LEF = 5;

    // Receiver config bits (BQL..BQH is the bit-quotient field)
    localparam int C_RXC_PCE = 0;
    localparam int C_RXC_BQL = 1;
    localparam int C_RXC_BQH = 6;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PEND = 2'd1,
        ST_DONE = 2'd2
    } cfg_state_t;

endpackage
`default_nettype wire

// File: rtl/sl_word_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : sl_word_fifo
//  Purpose  : Small word FIFO with wrapping pointers and occupancy count.
//  Revision : 1.0
// ============================================================================
module sl_word_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32,
    parameter int PTR_W = $clog2(DEPTH),
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] head,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_do_pop;
    logic             w_do_push;

    assign empty = (r_count == '0);
    assign full  = (r_count == CNT_W'(DEPTH));
    assign count = r_count;
    assign head  = r_mem[r_rd_ptr];

    // A pop frees the slot a same-cycle push into a full FIFO needs.
    assign w_do_pop  = pop & ~empty;
    assign w_do_push = push & (~full | w_do_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr] <= wdata;
    end

endmodule
`default_nettype wire

// File: rtl/sl_rx_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : sl_rx_ctrl
//  Purpose  : Host register front-end for the serial-link receiver: config
//             handshake FSM, captured-word FIFO, error flags and interrupt.
//  Revision : 1.0
// ============================================================================
module sl_rx_ctrl
    import sl_pkg::*;
#(
    parameter int STATUS_WIDTH = 16,
    parameter int CONFIG_WIDTH = 16,
    parameter int CFG_TIMEOUT  = 255
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [1:0]              host_addr,
    input  logic                    host_wr,
    input  logic                    host_rd,
    input  logic [31:0]             host_wdata,
    output logic [31:0]             host_rdata,
    output logic                    host_rvalid,
    output logic                    irq,
    input  logic [STATUS_WIDTH-1:0] rx_status_w,
    input  logic [31:0]             rx_data_w,
    input  logic [CONFIG_WIDTH-1:0] rx_config_w,
    input  logic                    rx_changed,
    output logic [CONFIG_WIDTH-1:0] rx_wr_config,
    output logic                    rx_wr_enable
);

    localparam int TMO_W = (CFG_TIMEOUT < 2) ? 1 : $clog2(CFG_TIMEOUT + 1);

    cfg_state_t                        r_state;
    logic [TMO_W-1:0]                  r_tmo_cnt;
    logic [C_STAT_LEV:C_STAT_CFG_REJ]  r_flags;
    logic [7:0]                        r_err_cnt;
    logic [9:0]                        r_mask;

    logic [C_STAT_LEV:C_STAT_CFG_REJ]  w_flag_set;
    logic [C_STAT_LEV:C_STAT_CFG_REJ]  w_flag_clr;
    logic        w_wr_cfg, w_wr_stat, w_wr_mask, w_rd_fifo;
    logic        w_cfg_bad, w_match, w_tmo_hit;
    logic        w_wrf, w_push, w_pe_ev, w_le_ev, w_lev_ev;
    logic [1:0]  w_err_inc;
    logic [8:0]  w_err_sum;
    logic [31:0] w_stat, w_rd_mux, w_fifo_head;
    logic [2:0]  w_fifo_count;
    logic        w_fifo_full, w_fifo_empty;
    logic        w_unused;

    assign w_wr_cfg  = host_wr & (host_addr == C_ADDR_CFG);
    assign w_wr_stat = host_wr & (host_addr == C_ADDR_STAT);
    assign w_wr_mask = host_wr & (host_addr == C_ADDR_MASK);
    assign w_rd_fifo = host_rd & (host_addr == C_ADDR_FIFO);

    assign w_cfg_bad = (host_wdata[C_RXC_BQH:C_RXC_BQL] < 6'd8) | host_wdata[C_RXC_BQL];
    assign w_match   = (rx_config_w == rx_wr_config);
    assign w_tmo_hit = (r_tmo_cnt == TMO_W'(CFG_TIMEOUT));

    assign w_wrf    = rx_changed & rx_status_w[C_RXS_WRF];
    assign w_push   = w_wrf & ~rx_status_w[C_RXS_PEF] & ~rx_status_w[C_RXS_WLC];
    assign w_pe_ev  = w_wrf & rx_status_w[C_RXS_PEF];
    assign w_le_ev  = w_wrf & rx_status_w[C_RXS_WLC];
    assign w_lev_ev = rx_changed & rx_status_w[C_RXS_LEF];

    always_comb begin
        w_flag_set                 = '0;
        w_flag_set[C_STAT_CFG_REJ] = w_wr_cfg & ((r_state != ST_IDLE) | w_cfg_bad);
        w_flag_set[C_STAT_CFG_TMO] = (r_state == ST_PEND) & ~w_match & w_tmo_hit;
        w_flag_set[C_STAT_OVF]     = w_push & w_fifo_full & ~w_rd_fifo;
        w_flag_set[C_STAT_PE]      = w_pe_ev;
        w_flag_set[C_STAT_LE]      = w_le_ev;
        w_flag_set[C_STAT_LEV]     = w_lev_ev;
    end

    assign w_flag_clr = w_wr_stat ? host_wdata[C_STAT_LEV:C_STAT_CFG_REJ] : '0;
    assign w_err_inc  = {1'b0, w_pe_ev} + {1'b0, w_le_ev} + {1'b0, w_lev_ev};
    assign w_err_sum  = {1'b0, (w_wr_stat & host_wdata[31]) ? 8'd0 : r_err_cnt} + {7'd0, w_err_inc};

    always_comb begin
        w_stat                                = '0;
        w_stat[C_STAT_CNT_MSB:C_STAT_CNT_LSB] = w_fifo_count;
        w_stat[C_STAT_CFG_BUSY]               = (r_state == ST_PEND);
        w_stat[C_STAT_LEV:C_STAT_CFG_REJ]     = r_flags;
        w_stat[C_STAT_ERR_MSB:C_STAT_ERR_LSB] = r_err_cnt;
    end

    always_comb begin
        w_rd_mux = '0;
        case (host_addr)
            C_ADDR_CFG:  w_rd_mux = 32'(rx_config_w);
            C_ADDR_FIFO: w_rd_mux = w_fifo_empty ? 32'd0 : w_fifo_head;
            C_ADDR_STAT: w_rd_mux = w_stat;
            default:     w_rd_mux = {22'd0, r_mask};
        endcase
    end

    sl_word_fifo #(
        .DEPTH (4),
        .WIDTH (32)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (w_push),
        .pop   (w_rd_fifo),
        .wdata (rx_data_w),
        .head  (w_fifo_head),
        .count (w_fifo_count),
        .full  (w_fifo_full),
        .empty (w_fifo_empty)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_tmo_cnt    <= '0;
            rx_wr_enable <= 1'b0;
            rx_wr_config <= CONFIG_WIDTH'(16'h0010);
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_wr_cfg && !w_cfg_bad) begin
                        r_state      <= ST_PEND;
                        rx_wr_config <= host_wdata[CONFIG_WIDTH-1:0];
                        r_tmo_cnt    <= '0;
                        rx_wr_enable <= 1'b1;
                    end
                end
                ST_PEND: begin
                    if (w_match || w_tmo_hit) begin
                        r_state      <= ST_DONE;
                        rx_wr_enable <= 1'b0;
                    end else begin
                        r_tmo_cnt <= r_tmo_cnt + 1'b1;
                    end
                end
                ST_DONE: r_state <= ST_IDLE;
                default: begin
                    r_state      <= ST_IDLE;
                    rx_wr_enable <= 1'b0;
                end
            endcase
        end
    end

    // Set beats clear when both land in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_flags     <= '0;
            r_err_cnt   <= '0;
            r_mask      <= '0;
            irq         <= 1'b0;
            host_rdata  <= '0;
            host_rvalid <= 1'b0;
        end else begin
            r_flags     <= w_flag_set | (r_flags & ~w_flag_clr);
            r_err_cnt   <= w_err_sum[8] ? 8'hFF : w_err_sum[7:0];
            irq         <= (r_mask[0] & ~w_fifo_empty) | (|(r_mask[9:4] & r_flags));
            host_rvalid <= host_rd;
            if (w_wr_mask) r_mask <= host_wdata[9:0];
            if (host_rd) host_rdata <= w_rd_mux;
        end
    end

    assign w_unused = ^{host_wdata, rx_status_w, host_wdata[C_RXC_PCE], rx_status_w[C_RXS_WRP]};

endmodule
`default_nettype wire
